line_direction_encoder: RTL and testbench



---
 rtl/line_direction_encoder.sv | 194 +++++++++++++++++++
 tb/tb_line_direction_encoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/line_direction_encoder.sv
// Line-follower front end: synchronises and debounces the five IR sensors, classifies
// the line position and drives the 4-bit dirControl command for the drive block.
module line_direction_encoder #(
    parameter int SAMPLE_DIV   = 100_000,
    parameter int DEBOUNCE_N   = 4,
    parameter int JNC_CONFIRM  = 3,
    parameter int LOST_TIMEOUT = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sensors,
    output logic [3:0] dirControl,
    output logic       jncPulse,
    output logic       lineLost
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV) + 1;
    localparam int ST_W   = $clog2(DEBOUNCE_N) + 1;
    localparam int JNC_W  = $clog2(JNC_CONFIRM) + 1;
    localparam int LOST_W = $clog2(LOST_TIMEOUT) + 1;

    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [ST_W-1:0]   DEB_MAX  = ST_W'(DEBOUNCE_N);
    localparam logic [JNC_W-1:0]  JNC_MAX  = JNC_W'(JNC_CONFIRM);
    localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_TIMEOUT);

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_TRACK    = 3'd1;
    localparam logic [2:0] S_CONFIRM  = 3'd2;
    localparam logic [2:0] S_JUNCTION = 3'd3;
    localparam logic [2:0] S_SEARCH   = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    localparam logic [1:0] C_TRACK = 2'd0;
    localparam logic [1:0] C_JNC   = 2'd1;
    localparam logic [1:0] C_BLANK = 2'd2;
    localparam logic [1:0] C_HOLD  = 2'd3;

    logic [4:0]        sync1, sync2;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [4:0]        candidate, filtered;
    logic [ST_W-1:0]   stable_cnt;
    logic [1:0]        cls;
    logic [3:0]        cls_code;
    logic [2:0]        state, state_nx;
    logic [3:0]        dir_nx;
    logic              pulse_nx;
    logic [JNC_W-1:0]  jnc_cnt, jnc_nx;
    logic [LOST_W-1:0] lost_cnt, lost_nx;
    logic [1:0]        last_side;

    assign tick     = (div_cnt == DIV_MAX);
    assign lineLost = (state == S_SEARCH) || (state == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            div_cnt <= '0;
        end else begin
            sync1   <= sensors;
            sync2   <= sync1;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    // A pattern becomes the filtered value on the tick its run length reaches DEBOUNCE_N.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            candidate  <= '0;
            filtered   <= '0;
            stable_cnt <= '0;
        end else if (tick) begin
            if (sync2 == candidate) begin
                if (stable_cnt != DEB_MAX) begin
                    stable_cnt <= stable_cnt + 1'b1;
                    if (stable_cnt + 1'b1 == DEB_MAX)
                        filtered <= candidate;
                end
            end else begin
                candidate  <= sync2;
                stable_cnt <= ST_W'(1);
                if (DEBOUNCE_N == 1)
                    filtered <= sync2;
            end
        end
    end

    always_comb begin
        cls      = C_HOLD;
        cls_code = 4'b1111;
        case (filtered)
            5'b00100, 5'b01110:           begin cls = C_TRACK; cls_code = 4'b0000; end
            5'b01100, 5'b01000:           begin cls = C_TRACK; cls_code = 4'b0101; end
            5'b11000, 5'b10000, 5'b11100: begin cls = C_TRACK; cls_code = 4'b0110; end
            5'b00110, 5'b00010:           begin cls = C_TRACK; cls_code = 4'b1001; end
            5'b00011, 5'b00001, 5'b00111: begin cls = C_TRACK; cls_code = 4'b1010; end
            5'b11111, 5'b11110, 5'b01111: cls = C_JNC;
            5'b00000:                     cls = C_BLANK;
            default:                      cls = C_HOLD;
        endcase
    end

    // A junction sample only counts on a tick whose raw sample still agrees with filtered.
    always_comb begin
        state_nx = state;
        dir_nx   = dirControl;
        pulse_nx = 1'b0;
        jnc_nx   = jnc_cnt;
        lost_nx  = lost_cnt;
        case (state)
            S_INIT, S_JUNCTION, S_HALT: begin
                if (cls == C_TRACK) begin
                    state_nx = S_TRACK;
                    dir_nx   = cls_code;
                end
            end
            S_TRACK: begin
                case (cls)
                    C_TRACK: dir_nx = cls_code;
                    C_JNC: begin
                        state_nx = S_CONFIRM;
                        jnc_nx   = JNC_W'(1);
                    end
                    C_BLANK: begin
                        state_nx = S_SEARCH;
                        lost_nx  = '0;
                        dir_nx   = {last_side, 2'b11};
                    end
                    default: ;
                endcase
            end
            S_CONFIRM: begin
                if (cls == C_TRACK) begin
                    state_nx = S_TRACK;
                    dir_nx   = cls_code;
                end else if (cls == C_BLANK) begin
                    state_nx = S_SEARCH;
                    lost_nx  = '0;
                    dir_nx   = {last_side, 2'b11};
                end else if (cls == C_JNC && tick && sync2 == filtered) begin
                    if (jnc_cnt + 1'b1 >= JNC_MAX) begin
                        state_nx = S_JUNCTION;
                        dir_nx   = 4'b1111;
                        pulse_nx = 1'b1;
                        jnc_nx   = JNC_MAX;
                    end else begin
                        jnc_nx = jnc_cnt + 1'b1;
                    end
                end
            end
            S_SEARCH: begin
                if (cls == C_TRACK) begin
                    state_nx = S_TRACK;
                    dir_nx   = cls_code;
                end else if (cls == C_JNC) begin
                    state_nx = S_CONFIRM;
                    jnc_nx   = JNC_W'(1);
                end else if (lost_cnt >= LOST_MAX) begin
                    state_nx = S_HALT;
                    dir_nx   = 4'b1111;
                end else if (tick) begin
                    lost_nx = lost_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = S_INIT;
                dir_nx   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_INIT;
            dirControl <= 4'b1111;
            jncPulse   <= 1'b0;
            jnc_cnt    <= '0;
            lost_cnt   <= '0;
            last_side  <= 2'b01;
        end else begin
            state      <= state_nx;
            dirControl <= dir_nx;
            jncPulse   <= pulse_nx;
            jnc_cnt    <= jnc_nx;
            lost_cnt   <= lost_nx;
            // Only veer/hard turn codes carry a side; pivot and stop codes use modifier 11.
            if (dir_nx[1:0] != 2'b11 && dir_nx[3:2] != 2'b00)
                last_side <= dir_nx[3:2];
        end
    end

endmodule

// File: tb/tb_line_direction_encoder.sv
// Directed bench for line_direction_encoder using the reduced simulation parameters.
module tb_line_direction_encoder;

    localparam int SAMPLE_DIV   = 4;
    localparam int DEBOUNCE_N   = 3;
    localparam int JNC_CONFIRM  = 2;
    localparam int LOST_TIMEOUT = 5;
    localparam int NUM_VECS     = 15;

    typedef struct {
        logic [4:0] pattern;
        logic [3:0] expDir;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sensors;
    logic [3:0] dirControl;
    logic       jncPulse;
    logic       lineLost;

    int   checks      = 0;
    int   failures    = 0;
    int   pulseCount  = 0;
    int   pulseBase;
    vec_t vecs [NUM_VECS];

    always #5 clk = ~clk;

    line_direction_encoder #(
        .SAMPLE_DIV  (SAMPLE_DIV),
        .DEBOUNCE_N  (DEBOUNCE_N),
        .JNC_CONFIRM (JNC_CONFIRM),
        .LOST_TIMEOUT(LOST_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensors   (sensors),
        .dirControl(dirControl),
        .jncPulse  (jncPulse),
        .lineLost  (lineLost)
    );

    // A pulse longer than one clk shows up as an extra count.
    always @(negedge clk) begin
        if (jncPulse === 1'b1)
            pulseCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] pattern, input int ticks);
        sensors = pattern;
        repeat (ticks * SAMPLE_DIV) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{5'b01100, 4'b0101, "veer_left_01100"};
        vecs[1]  = '{5'b11000, 4'b0110, "hard_left_11000"};
        vecs[2]  = '{5'b01000, 4'b0101, "veer_left_01000"};
        vecs[3]  = '{5'b10000, 4'b0110, "hard_left_10000"};
        vecs[4]  = '{5'b11100, 4'b0110, "hard_left_11100"};
        vecs[5]  = '{5'b10101, 4'b0110, "hold_10101"};
        vecs[6]  = '{5'b00110, 4'b1001, "veer_right_00110"};
        vecs[7]  = '{5'b00010, 4'b1001, "veer_right_00010"};
        vecs[8]  = '{5'b00011, 4'b1010, "hard_right_00011"};
        vecs[9]  = '{5'b00001, 4'b1010, "hard_right_00001"};
        vecs[10] = '{5'b00111, 4'b1010, "hard_right_00111"};
        vecs[11] = '{5'b01010, 4'b1010, "hold_01010"};
        vecs[12] = '{5'b01110, 4'b0000, "proceed_01110"};
        vecs[13] = '{5'b10001, 4'b0000, "hold_10001"};
        vecs[14] = '{5'b00100, 4'b0000, "proceed_00100"};

        rst     = 1'b0;
        sensors = 5'b00100;
        repeat (3) @(negedge clk);
        checkOutput("reset_dir", dirControl, 4'b1111);
        checkOutput("reset_pulse", jncPulse, 1'b0);
        checkOutput("reset_lost", lineLost, 1'b0);

        // Ticks land on the 4th, 8th and 12th edges after release.
        rst = 1'b1;
        repeat (11) @(negedge clk);
        checkOutput("init_hold", dirControl, 4'b1111);
        repeat (3) @(negedge clk);
        checkOutput("init_proceed", dirControl, 4'b0000);
        checkOutput("init_lost", lineLost, 1'b0);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].pattern, 4);
            checkOutput(vecs[i].name, dirControl, vecs[i].expDir);
            checkOutput({vecs[i].name, "_lost"}, lineLost, 1'b0);
        end

        applyStimulus(5'b00001, 1);
        checkOutput("glitch_during", dirControl, 4'b0000);
        applyStimulus(5'b00100, 4);
        checkOutput("glitch_after", dirControl, 4'b0000);

        pulseBase = pulseCount;
        applyStimulus(5'b11111, 5);
        checkOutput("jnc_dir", dirControl, 4'b1111);
        checkOutput("jnc_pulses", pulseCount - pulseBase, 1);
        checkOutput("jnc_lost", lineLost, 1'b0);
        applyStimulus(5'b00100, 4);
        checkOutput("jnc_exit_dir", dirControl, 4'b0000);
        checkOutput("jnc_exit_pulses", pulseCount - pulseBase, 1);

        applyStimulus(5'b11111, 3);
        checkOutput("short_jnc_dir", dirControl, 4'b0000);
        applyStimulus(5'b00100, 4);
        checkOutput("short_jnc_exit_dir", dirControl, 4'b0000);
        checkOutput("short_jnc_pulses", pulseCount - pulseBase, 1);

        applyStimulus(5'b00110, 4);
        checkOutput("pre_search_dir", dirControl, 4'b1001);
        sensors = 5'b00000;
        repeat (16) @(negedge clk);
        checkOutput("search_right_dir", dirControl, 4'b1011);
        checkOutput("search_right_lost", lineLost, 1'b1);
        repeat (14) @(negedge clk);
        checkOutput("search_before_timeout", dirControl, 4'b1011);
        repeat (6) @(negedge clk);
        checkOutput("halt_dir", dirControl, 4'b1111);
        checkOutput("halt_lost", lineLost, 1'b1);
        applyStimulus(5'b00100, 4);
        checkOutput("halt_exit_dir", dirControl, 4'b0000);
        checkOutput("halt_exit_lost", lineLost, 1'b0);

        applyStimulus(5'b01000, 4);
        checkOutput("pre_left_search_dir", dirControl, 4'b0101);
        sensors = 5'b00000;
        repeat (16) @(negedge clk);
        checkOutput("search_left_dir", dirControl, 4'b0111);
        checkOutput("search_left_lost", lineLost, 1'b1);

        // Reset lands between clock edges, so any change must come from the async path.
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_dir", dirControl, 4'b1111);
        checkOutput("async_reset_pulse", jncPulse, 1'b0);
        checkOutput("async_reset_lost", lineLost, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
